// File: rtl/pc_seq_pkg.sv
// Shared types and constants for the PC sequencer.
// PC_SEQ_TRAP_EN (optional) adds the trap redirect.
package pc_seq_pkg;

  localparam int unsigned     PC_W       = 32;
  localparam logic [PC_W-1:0] PC_INC     = 32'd4;
  localparam logic [PC_W-1:0] ALIGN_MASK = 32'hFFFF_FFFC;

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_FETCH = 2'd1,
    ST_STALL = 2'd2,
    ST_HALT  = 2'd3
  } state_t;

  // Redirect priority levels; a larger value wins.
  localparam logic [1:0] PRI_NONE   = 2'd0;
  localparam logic [1:0] PRI_BRANCH = 2'd1;
  localparam logic [1:0] PRI_JUMP   = 2'd2;
  localparam logic [1:0] PRI_TRAP   = 2'd3;

  function automatic logic [PC_W-1:0] align_pc(input logic [PC_W-1:0] addr);
    return addr & ALIGN_MASK;
  endfunction

endpackage

// File: rtl/pc_next_mux.sv
// Next-PC candidates: sequential pc+4 and the highest-priority aligned redirect.
// PC_SEQ_TRAP_EN adds the trap input and TRAP_VECTOR.
module pc_next_mux
  import pc_seq_pkg::*;
`ifdef PC_SEQ_TRAP_EN
#(
  parameter logic [PC_W-1:0] TRAP_VECTOR = 32'h0000_0100
)
`endif
(
  input  logic [PC_W-1:0] i_pc,
`ifdef PC_SEQ_TRAP_EN
  input  logic            i_trap,
`endif
  input  logic            i_jump,
  input  logic [PC_W-1:0] i_jump_target,
  input  logic            i_branch,
  input  logic [PC_W-1:0] i_branch_target,
  output logic [PC_W-1:0] o_seq_pc,
  output logic [1:0]      o_redir_pri,
  output logic [PC_W-1:0] o_redir_tgt
);

  assign o_seq_pc = i_pc + PC_INC;

  // Priority select of the redirect source present this cycle.
  always_comb begin
    o_redir_pri = PRI_NONE;
    o_redir_tgt = {PC_W{1'b0}};
`ifdef PC_SEQ_TRAP_EN
    if (i_trap) begin
      o_redir_pri = PRI_TRAP;
      o_redir_tgt = align_pc(TRAP_VECTOR);
    end else
`endif
    if (i_jump) begin
      o_redir_pri = PRI_JUMP;
      o_redir_tgt = align_pc(i_jump_target);
    end else if (i_branch) begin
      o_redir_pri = PRI_BRANCH;
      o_redir_tgt = align_pc(i_branch_target);
    end else begin
      o_redir_pri = PRI_NONE;
      o_redir_tgt = {PC_W{1'b0}};
    end
  end

endmodule

// File: rtl/pc_seq_ctrl.sv
// Instruction-fetch PC sequencer: BOOT/FETCH/STALL/HALT FSM with redirect latch.
// PC_SEQ_TRAP_EN adds the trap port, TRAP_VECTOR and trap exit from HALT.
module pc_seq_ctrl
  import pc_seq_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_VECTOR = 32'h0000_0000
`ifdef PC_SEQ_TRAP_EN
  ,
  parameter logic [PC_W-1:0] TRAP_VECTOR  = 32'h0000_0100
`endif
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic            stall,
  input  logic            halt,
  input  logic            branch_taken,
  input  logic [PC_W-1:0] branch_target,
  input  logic            jump,
  input  logic [PC_W-1:0] jump_target,
`ifdef PC_SEQ_TRAP_EN
  input  logic            trap,
`endif
  output logic [PC_W-1:0] pc,
  output logic            instr_valid,
  output logic [PC_W-1:0] instr_pc,
  output logic            halted
);

  state_t          r_state;
  logic [PC_W-1:0] r_pc;
  logic [PC_W-1:0] r_instr_pc;
  logic            r_instr_valid;
  logic            r_imem_req;
  logic            r_halted;
  logic [1:0]      r_lat_pri;
  logic [PC_W-1:0] r_lat_tgt;

  logic [PC_W-1:0] w_seq_pc;
  logic [1:0]      w_cur_pri;
  logic [PC_W-1:0] w_cur_tgt;
  logic            w_use_cur;
  logic [1:0]      w_best_pri;
  logic [PC_W-1:0] w_best_tgt;

`ifdef PC_SEQ_TRAP_EN
  pc_next_mux #(.TRAP_VECTOR(TRAP_VECTOR)) u_next_mux (
    .i_pc            (r_pc),
    .i_trap          (trap),
`else
  pc_next_mux u_next_mux (
    .i_pc            (r_pc),
`endif
    .i_jump          (jump),
    .i_jump_target   (jump_target),
    .i_branch        (branch_taken),
    .i_branch_target (branch_target),
    .o_seq_pc        (w_seq_pc),
    .o_redir_pri     (w_cur_pri),
    .o_redir_tgt     (w_cur_tgt)
  );

  // A same-cycle redirect only displaces the latched one if strictly higher priority.
  assign w_use_cur  = (w_cur_pri > r_lat_pri);
  assign w_best_pri = w_use_cur ? w_cur_pri : r_lat_pri;
  assign w_best_tgt = w_use_cur ? w_cur_tgt : r_lat_tgt;

  // Sequencer FSM with all outputs registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= ST_BOOT;
      r_pc          <= RESET_VECTOR;
      r_instr_pc    <= RESET_VECTOR;
      r_instr_valid <= 1'b0;
      r_imem_req    <= 1'b0;
      r_halted      <= 1'b0;
      r_lat_pri     <= PRI_NONE;
      r_lat_tgt     <= {PC_W{1'b0}};
    end else begin
      r_instr_valid <= 1'b0;
      case (r_state)
        ST_BOOT: begin
          r_state    <= ST_FETCH;
          r_imem_req <= 1'b1;
        end
        ST_FETCH: begin
          if (imem_ack) begin
            r_lat_pri <= PRI_NONE;
            r_lat_tgt <= {PC_W{1'b0}};
            if (w_best_pri != PRI_NONE) begin
              r_pc <= w_best_tgt;
            end else begin
              r_pc          <= w_seq_pc;
              r_instr_pc    <= r_pc;
              r_instr_valid <= 1'b1;
            end
            if (halt) begin
              r_state    <= ST_HALT;
              r_imem_req <= 1'b0;
              r_halted   <= 1'b1;
            end else if (stall) begin
              r_state    <= ST_STALL;
              r_imem_req <= 1'b0;
            end else begin
              r_state    <= ST_FETCH;
              r_imem_req <= 1'b1;
            end
          end else if (w_use_cur) begin
            r_lat_pri <= w_cur_pri;
            r_lat_tgt <= w_cur_tgt;
          end
        end
        ST_STALL: begin
          if (w_cur_pri != PRI_NONE) begin
            r_pc <= w_cur_tgt;
          end
          if (halt) begin
            r_state    <= ST_HALT;
            r_halted   <= 1'b1;
            r_imem_req <= 1'b0;
          end else if (!stall) begin
            r_state    <= ST_FETCH;
            r_imem_req <= 1'b1;
          end
        end
        ST_HALT: begin
`ifdef PC_SEQ_TRAP_EN
          if (w_cur_pri == PRI_TRAP) begin
            r_pc       <= w_cur_tgt;
            r_state    <= ST_FETCH;
            r_imem_req <= 1'b1;
            r_halted   <= 1'b0;
          end else begin
            r_state <= ST_HALT;
          end
`else
          r_state <= ST_HALT;
`endif
        end
        default: begin
          r_state    <= ST_BOOT;
          r_imem_req <= 1'b0;
          r_halted   <= 1'b0;
        end
      endcase
    end
  end

  assign imem_req    = r_imem_req;
  assign imem_addr   = r_pc;
  assign pc          = r_pc;
  assign instr_valid = r_instr_valid;
  assign instr_pc    = r_instr_pc;
  assign halted      = r_halted;

endmodule

// File: tb/tb_pc_seq_ctrl.sv
// Self-checking bench for pc_seq_ctrl: directed scenarios then randomized traffic
// against a flag-based reference model. Build with PC_SEQ_TRAP_EN to cover traps.
module tb_pc_seq_ctrl;

  localparam logic [31:0] RV = 32'h0000_0000;
  localparam logic [31:0] TV = 32'h0000_0100;
`ifdef PC_SEQ_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, imem_req, imem_ack, stall, halt, branch_taken, jump, trap;
  logic        instr_valid, halted;
  logic [31:0] imem_addr, branch_target, jump_target, pc, instr_pc;

  always #5 clk = ~clk;

  pc_seq_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ack      (imem_ack),
    .stall         (stall),
    .halt          (halt),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .jump          (jump),
    .jump_target   (jump_target),
`ifdef PC_SEQ_TRAP_EN
    .trap          (trap),
`endif
    .pc            (pc),
    .instr_valid   (instr_valid),
    .instr_pc      (instr_pc),
    .halted        (halted)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: plain flags for what the sequencer is doing.
  logic [31:0] m_pc, m_ipc, m_pend_tgt;
  bit          m_valid, m_boot, m_stalled, m_halted;
  int          m_pend_pri;

  function automatic bit m_fetching();
    return !m_boot && !m_stalled && !m_halted;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_step();
    int          cp;
    logic [31:0] ct;
    cp = 0;
    ct = 32'h0;
    if (TRAP_EN && trap === 1'b1) begin cp = 3; ct = TV & ~32'd3; end
    else if (jump)                begin cp = 2; ct = jump_target & ~32'd3; end
    else if (branch_taken)        begin cp = 1; ct = branch_target & ~32'd3; end
    m_valid = 1'b0;
    if (rst) begin
      m_pc = RV; m_ipc = RV; m_boot = 1'b1; m_stalled = 1'b0; m_halted = 1'b0;
      m_pend_pri = 0; m_pend_tgt = 32'h0;
    end else if (m_boot) begin
      m_boot = 1'b0;
    end else if (m_halted) begin
      if (cp == 3) begin m_pc = ct; m_halted = 1'b0; end
    end else if (m_stalled) begin
      if (cp != 0) m_pc = ct;
      if (halt) begin m_halted = 1'b1; m_stalled = 1'b0; end
      else if (!stall) m_stalled = 1'b0;
    end else if (imem_ack) begin
      if (cp > m_pend_pri) begin m_pend_pri = cp; m_pend_tgt = ct; end
      if (m_pend_pri != 0) m_pc = m_pend_tgt;
      else begin m_valid = 1'b1; m_ipc = m_pc; m_pc = m_pc + 32'd4; end
      m_pend_pri = 0;
      if (halt) m_halted = 1'b1;
      else if (stall) m_stalled = 1'b1;
    end else if (cp > m_pend_pri) begin
      m_pend_pri = cp; m_pend_tgt = ct;
    end
  endtask

  // One clock: advance the model with the current inputs, then compare all outputs.
  task automatic step();
    model_step();
    @(posedge clk);
    #1;
    check_eq("imem_req",    32'(imem_req),    32'(m_fetching()));
    check_eq("imem_addr",   imem_addr,        m_pc);
    check_eq("pc",          pc,               m_pc);
    check_eq("instr_valid", 32'(instr_valid), 32'(m_valid));
    check_eq("instr_pc",    instr_pc,         m_ipc);
    check_eq("halted",      32'(halted),      32'(m_halted));
  endtask

  task automatic clear_in();
    rst = 1'b0; imem_ack = 1'b0; stall = 1'b0; halt = 1'b0; trap = 1'b0;
    branch_taken = 1'b0; jump = 1'b0; branch_target = 32'h0; jump_target = 32'h0;
  endtask

  task automatic do_reset();
    clear_in();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  initial begin
    m_pc = RV; m_ipc = RV; m_pend_tgt = 32'h0; m_pend_pri = 0;
    m_valid = 1'b0; m_boot = 1'b1; m_stalled = 1'b0; m_halted = 1'b0;
    clear_in();
    #1;
    do_reset();
    check_eq("reset_pc", pc, RV);
    check_eq("reset_req", 32'(imem_req), 32'd0);

    // Boot cycle, then sequential fetch.
    step();
    check_eq("boot_addr", imem_addr, 32'h0);
    for (int i = 1; i <= 2; i++) begin
      imem_ack = 1'b1;
      step();
      check_eq("seq_addr", imem_addr, 32'(i * 4));
      check_eq("seq_ipc", instr_pc, 32'((i - 1) * 4));
    end

    // Branch latched while waiting at pc 8, applied on the later ack.
    imem_ack = 1'b0; branch_taken = 1'b1; branch_target = 32'h0000_0203;
    step();
    branch_taken = 1'b0; imem_ack = 1'b1;
    step();
    check_eq("latched_br_valid", 32'(instr_valid), 32'd0);
    check_eq("latched_br_pc", pc, 32'h0000_0200);

    // Jump beats branch in the same cycle.
    jump = 1'b1; jump_target = 32'h40; branch_taken = 1'b1; branch_target = 32'h80;
    step();
    check_eq("jump_over_branch", pc, 32'h40);

    // pc+4 wraps at the top of the address space.
    branch_taken = 1'b0; jump_target = 32'hFFFF_FFFC;
    step();
    jump = 1'b0;
    step();
    check_eq("wrap_pc", pc, 32'h0);

    // Stall raised before ack: ack completes, then 3 idle cycles.
    imem_ack = 1'b0; stall = 1'b1;
    step();
    check_eq("stall_keeps_req", 32'(imem_req), 32'd1);
    imem_ack = 1'b1;
    step();
    imem_ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check_eq("stall_req_low", 32'(imem_req), 32'd0);
      check_eq("stall_pc_held", pc, 32'h4);
      if (i == 2) stall = 1'b0;
      step();
    end
    check_eq("stall_resume", 32'(imem_req), 32'd1);

    // Halt mid-fetch, then reset out of HALT.
    halt = 1'b1;
    step();
    imem_ack = 1'b1;
    step();
    imem_ack = 1'b0; halt = 1'b0;
    check_eq("halt_after_ack", 32'(halted), 32'd1);
    step();
`ifdef PC_SEQ_TRAP_EN
    trap = 1'b1;
    step();
    trap = 1'b0;
    check_eq("trap_pc", pc, 32'h100);
    check_eq("trap_fetch", 32'(imem_req), 32'd1);
    halt = 1'b1; imem_ack = 1'b1;
    step();
    halt = 1'b0; imem_ack = 1'b0;
`endif
    do_reset();
    check_eq("halt_rst_halted", 32'(halted), 32'd0);
    check_eq("halt_rst_pc", pc, RV);

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      clear_in();
      rst          = ($urandom_range(m_halted ? 7 : 79, 0) == 0);
      imem_ack     = m_fetching() && ($urandom_range(1, 0) == 1);
      stall        = ($urandom_range(3, 0) == 0);
      halt         = ($urandom_range(39, 0) == 0);
      trap         = TRAP_EN && ($urandom_range(19, 0) == 0);
      jump         = ($urandom_range(7, 0) == 0);
      branch_taken = ($urandom_range(5, 0) == 0);
      jump_target  = ($urandom_range(3, 0) == 0) ? (32'hFFFF_FFF8 | 32'($urandom_range(7, 0))) : $urandom;
      branch_target = $urandom;
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pc_seq_ctrl.md
PC_SEQ_CTRL -- requirements
Module: pc_seq_ctrl

Interface
REQ-001 SHALL have parameter RESET_VECTOR, default 32'h0000_0000: PC value loaded on reset.
REQ-002 SHALL have parameter TRAP_VECTOR, default 32'h0000_0100: trap redirect target (TRAP_EN only).
REQ-003 SHALL have port clk  input  1: single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1: reset, synchronous, active-high.
REQ-005 SHALL have ports imem_req output 1 (fetch request) and imem_addr output 32 (fetch address, always equal to pc).
REQ-006 SHALL have port imem_ack  input  1: fetch accepted/completed; valid only while imem_req=1.
REQ-007 SHALL have ports stall input 1 (hold PC) and halt input 1 (stop fetching).
REQ-008 SHALL have ports branch_taken input 1 with branch_target input 32, and jump input 1 with jump_target input 32.
REQ-009 SHALL have port trap  input  1: exception request (present only with TRAP_EN).
REQ-010 SHALL have ports pc output 32 (current PC), instr_valid output 1 (fetched-word strobe), instr_pc output 32 (address of that word) and halted output 1.

Function
REQ-011 SHALL implement FSM states BOOT, FETCH, STALL, HALT.
REQ-012 BOOT SHALL last exactly one cycle after reset release, with imem_req=0, then go to FETCH.
REQ-013 In FETCH, imem_req SHALL be 1; the controller stays in FETCH until imem_ack=1.
REQ-014 On imem_ack in FETCH with no redirect, instr_valid SHALL be 1 and instr_pc SHALL equal the acked pc in the next cycle (registered, 1-cycle latency), and pc SHALL update to next-PC.
REQ-015 Next-PC priority SHALL be: trap > jump > branch_taken > pc+4.
REQ-016 pc+4 SHALL be 32-bit modulo; 32'hFFFF_FFFC wraps to 32'h0000_0000.
REQ-017 Redirect targets SHALL have bits [1:0] forced to 0.
REQ-018 A redirect arriving in FETCH before ack SHALL be latched (highest priority kept if several arrive); on the later ack, that response SHALL be discarded (instr_valid=0) and pc <= latched target.
REQ-019 A redirect in the same cycle as imem_ack SHALL discard that response and load the redirect target.
REQ-020 stall=1 SHALL hold pc; in FETCH, stall takes effect only after the outstanding ack (request never withdrawn); the FSM then enters STALL with imem_req=0 and returns to FETCH the cycle after stall=0.
REQ-021 A redirect during STALL SHALL update pc immediately; state stays STALL.
REQ-022 halt=1 SHALL move the FSM to HALT once no request is outstanding; HALT drives imem_req=0 and halted=1 and exits only by reset.
REQ-023 instr_valid SHALL be a single-cycle pulse per accepted, non-discarded fetch.

Reset
REQ-024 rst=1 SHALL take priority over all inputs in every state, including mid-fetch; any outstanding ack is ignored.
REQ-025 Reset values SHALL be: pc=instr_pc=RESET_VECTOR, imem_req=0, instr_valid=0, halted=0, redirect latch cleared, state=BOOT.

Configuration
REQ-026 Macro PC_SEQ_TRAP_EN defined: trap port exists, trap redirects to TRAP_VECTOR at highest priority, and trap also exits HALT into FETCH.
REQ-027 Macro PC_SEQ_TRAP_EN undefined: no trap port and no TRAP_VECTOR use; priority is jump > branch > pc+4.

Structure
REQ-028 Package pc_seq_pkg SHALL hold the FSM state enum, PC_W=32 and PC_INC=32'd4.
REQ-029 Next-PC selection SHALL be a sub-module pc_next_mux (combinational: priority select, alignment, increment).

Verification
REQ-030 Reset then ack every cycle -> imem_addr 0,4,8,C; instr_valid pulses with instr_pc 0,4,8.
REQ-031 Branch to 32'h0000_0203 while waiting for ack at pc 8 -> on ack instr_valid=0, pc=32'h0000_0200.
REQ-032 jump (target 0x40) and branch (target 0x80) in the same cycle -> pc=0x40.
REQ-033 pc=32'hFFFF_FFFC, ack -> pc=32'h0000_0000.
REQ-034 stall for 3 cycles during FETCH -> ack completes, imem_req=0 for 3 cycles, pc held, then fetch resumes.
REQ-035 halt mid-fetch then rst mid-HALT -> halted=1 after ack; after rst, BOOT state, pc=RESET_VECTOR, halted=0; with PC_SEQ_TRAP_EN, trap in HALT -> pc=0x100, FETCH.
